// File: rtl/t_state_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// t_state_sequencer_pkg
//
// Shared definitions for the T-state sequencer, the control unit and the CPU
// top: sequencer state encodings and the default T-state geometry. Keeping
// them in one place means every block that decodes T agrees on the number of
// states and on the counter width.
// ---------------------------------------------------------------------------
package t_state_sequencer_pkg;

    // Sequencer top-level states.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

    // Default T-state geometry: eight T-states held in a 3-bit counter.
    localparam int DEF_T_WIDTH    = 3;
    localparam int DEF_NUM_T      = 8;
    localparam int DEF_ICNT_WIDTH = 16;

endpackage : t_state_sequencer_pkg

// File: rtl/t_state_sequencer_decoder.sv
// ---------------------------------------------------------------------------
// t_state_sequencer_decoder
//
// Generic binary-to-one-hot decoder with enable. Only the lowest N_OUT codes
// are decoded; select values at or above N_OUT produce all zeros, which lets
// the sequencer drop the unused top outputs when NUM_T < 2**WIDTH.
//
// Ports:
//   sel_i  [WIDTH-1:0]  binary select
//   en_i                1 = drive the selected output, 0 = all outputs low
//   dec_o  [N_OUT-1:0]  one-hot (or all-zero) decoded output
// ---------------------------------------------------------------------------
module t_state_sequencer_decoder #(
    parameter int WIDTH = 3,
    parameter int N_OUT = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] sel_i,
    input  logic             en_i,
    output logic [N_OUT-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (en_i && (sel_i == WIDTH'(i))) begin
                dec_o[i] = 1'b1;
            end
        end
    end

endmodule : t_state_sequencer_decoder

// File: rtl/t_state_sequencer.sv
// ---------------------------------------------------------------------------
// t_state_sequencer
//
// One-hot T-state generator for the CPU control unit. A binary T counter is
// advanced once per clock in RUN and decoded into one-hot strobes. The
// counter can be stalled by memory wait states, gated by a single-step debug
// mode, returned to T0 at the end of an instruction, or parked in HALT until
// a run pulse arrives. A counter that wraps without an end-of-instruction
// request sets a sticky overflow flag; every instruction boundary (explicit
// clear or wrap) is counted.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        synchronous active-high reset
//   hlt          halt request from the control unit
//   clr_timer    end-of-instruction request, return to T0
//   wait_req     memory/IO not ready, hold the current T-state
//   step_mode    1 = single-step debug mode
//   step_req     permits one advance per cycle while in step mode
//   run          resume pulse out of HALT
//   T            one-hot T-state strobes, T[0] = fetch
//   t_count      binary current T index
//   halted       sequencer is in HALT
//   ovf_err      sticky: counter wrapped past NUM_T-1 without clr_timer
//   instr_count  number of completed instructions (wraps)
// ---------------------------------------------------------------------------
module t_state_sequencer
    import t_state_sequencer_pkg::*;
#(
    parameter int T_WIDTH    = DEF_T_WIDTH,
    parameter int NUM_T      = DEF_NUM_T,
    parameter int ICNT_WIDTH = DEF_ICNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hlt,
    input  logic                  clr_timer,
    input  logic                  wait_req,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic                  run,
    output logic [NUM_T-1:0]      T,
    output logic [T_WIDTH-1:0]    t_count,
    output logic                  halted,
    output logic                  ovf_err,
    output logic [ICNT_WIDTH-1:0] instr_count
);

    localparam logic [T_WIDTH-1:0] LAST_T = T_WIDTH'(NUM_T - 1);

    seq_state_e            state_q;
    logic [T_WIDTH-1:0]    count_q;
    logic                  started_q;
    logic                  ovf_q;
    logic [ICNT_WIDTH-1:0] icnt_q;

    // In step mode the counter may only move on a cycle carrying step_req.
    logic step_ok;
    assign step_ok = !step_mode || step_req;

    // Sequencer FSM. Priority inside RUN: halt, step gating, wait, clear,
    // then normal advance / wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            count_q   <= '0;
            started_q <= 1'b0;
            ovf_q     <= 1'b0;
            icnt_q    <= '0;
        end else if (!started_q) begin
            // First edge after reset only arms the decoder so that T0 is
            // presented for a full cycle before the counter moves.
            started_q <= 1'b1;
        end else begin
            case (state_q)
                ST_HALT: begin
                    count_q <= '0;
                    if (run) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (hlt) begin
                        state_q <= ST_HALT;
                        count_q <= '0;
                    end else if (step_ok && !wait_req) begin
                        // A pending clr_timer is deferred while wait_req is
                        // high and ignored while step mode withholds a step.
                        if (clr_timer) begin
                            count_q <= '0;
                            icnt_q  <= icnt_q + ICNT_WIDTH'(1);
                        end else if (count_q == LAST_T) begin
                            count_q <= '0;
                            ovf_q   <= 1'b1;
                            icnt_q  <= icnt_q + ICNT_WIDTH'(1);
                        end else begin
                            count_q <= count_q + T_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // T strobes are live only once started and while running.
    logic dec_en;
    assign dec_en = started_q && (state_q == ST_RUN);

    t_state_sequencer_decoder #(
        .WIDTH (T_WIDTH),
        .N_OUT (NUM_T)
    ) u_t_decoder (
        .sel_i (count_q),
        .en_i  (dec_en),
        .dec_o (T)
    );

    assign t_count     = count_q;
    assign halted      = (state_q == ST_HALT);
    assign ovf_err     = ovf_q;
    assign instr_count = icnt_q;

endmodule : t_state_sequencer

// File: tb/tb_t_state_sequencer.sv
module tb_t_state_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_T = 8
    logic        reset, hlt, clr_timer, wait_req, step_mode, step_req, run;
    logic [7:0]  T;
    logic [2:0]  t_count;
    logic        halted, ovf_err;
    logic [15:0] instr_count;

    // Instance B: NUM_T = 5
    logic        b_reset, b_hlt, b_clr, b_wait, b_smode, b_sreq, b_run;
    logic [4:0]  b_T;
    logic [2:0]  b_tcount;
    logic        b_halted, b_ovf;
    logic [15:0] b_icnt;

    int n_cmp = 0;
    int n_err = 0;

    t_state_sequencer #(.T_WIDTH(3), .NUM_T(8), .ICNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .hlt(hlt), .clr_timer(clr_timer),
        .wait_req(wait_req), .step_mode(step_mode), .step_req(step_req),
        .run(run), .T(T), .t_count(t_count), .halted(halted),
        .ovf_err(ovf_err), .instr_count(instr_count)
    );

    t_state_sequencer #(.T_WIDTH(3), .NUM_T(5), .ICNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(b_reset), .hlt(b_hlt), .clr_timer(b_clr),
        .wait_req(b_wait), .step_mode(b_smode), .step_req(b_sreq),
        .run(b_run), .T(b_T), .t_count(b_tcount), .halted(b_halted),
        .ovf_err(b_ovf), .instr_count(b_icnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hlt = 1'b0; clr_timer = 1'b0; wait_req = 1'b0;
        step_mode = 1'b0; step_req = 1'b0; run = 1'b0;
        b_reset = 1'b1; b_hlt = 1'b0; b_clr = 1'b0; b_wait = 1'b0;
        b_smode = 1'b0; b_sreq = 1'b0; b_run = 1'b0;

        // Reset for two cycles
        tick(); tick();
        chk("rst_T", 32'(T), 32'h00);
        chk("rst_tcount", 32'(t_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_icnt", 32'(instr_count), 32'd0);

        // Free run: T0 for one cycle, then walk to T7 and wrap
        reset = 1'b0;
        chk("pre_start_T", 32'(T), 32'h00);
        tick();
        chk("run_T0", 32'(T), 32'h01);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("run_walk_T", 32'(T), 32'(1 << i));
            chk("run_walk_tcount", 32'(t_count), 32'(i));
        end
        chk("run_ovf_before_wrap", 32'(ovf_err), 32'd0);
        tick();
        chk("wrap_T", 32'(T), 32'h01);
        chk("wrap_ovf", 32'(ovf_err), 32'd1);
        chk("wrap_icnt", 32'(instr_count), 32'd1);

        // Fresh reset, then clr_timer at T1 one hundred times
        reset = 1'b1;
        tick();
        chk("rst2_ovf", 32'(ovf_err), 32'd0);
        chk("rst2_icnt", 32'(instr_count), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("clr_pre_T", 32'(T), 32'h02);
        for (int i = 0; i < 100; i++) begin
            clr_timer = 1'b1;
            tick();
            chk("clr_T0", 32'(T), 32'h01);
            clr_timer = 1'b0;
            tick();
        end
        chk("clr_icnt", 32'(instr_count), 32'd100);
        chk("clr_ovf", 32'(ovf_err), 32'd0);
        chk("clr_post_T", 32'(T), 32'h02);

        // Wait state at T2 with clr_timer also high: clear deferred
        tick();
        chk("wait_pre_T", 32'(T), 32'h04);
        wait_req = 1'b1;
        clr_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold_T", 32'(T), 32'h04);
            chk("wait_hold_icnt", 32'(instr_count), 32'd100);
        end
        wait_req = 1'b0;
        tick();
        chk("wait_clr_T", 32'(T), 32'h01);
        chk("wait_clr_icnt", 32'(instr_count), 32'd101);
        clr_timer = 1'b0;

        // Halt at T2, hold for 20 cycles while other inputs toggle
        tick();
        tick();
        chk("hlt_pre_T", 32'(T), 32'h04);
        hlt = 1'b1;
        tick();
        chk("hlt_T", 32'(T), 32'h00);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_tcount", 32'(t_count), 32'd0);
        hlt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clr_timer = i[0];
            wait_req  = i[1];
            step_req  = i[2];
            tick();
            chk("halt_hold_T", 32'(T), 32'h00);
            chk("halt_hold_halted", 32'(halted), 32'd1);
        end
        clr_timer = 1'b0; wait_req = 1'b0; step_req = 1'b0;
        chk("halt_icnt", 32'(instr_count), 32'd101);
        // run together with hlt: run wins
        run = 1'b1;
        hlt = 1'b1;
        tick();
        run = 1'b0;
        hlt = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_T", 32'(T), 32'h01);

        // Single step: hold at T1 for 5 cycles, clr_timer ignored
        tick();
        chk("step_pre_T", 32'(T), 32'h02);
        step_mode = 1'b1;
        clr_timer = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("step_hold_T", 32'(T), 32'h02);
        end
        clr_timer = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_one_T", 32'(T), 32'h04);
        tick();
        chk("step_hold2_T", 32'(T), 32'h04);
        step_req = 1'b1;
        tick();
        chk("step_held_a_T", 32'(T), 32'h08);
        tick();
        chk("step_held_b_T", 32'(T), 32'h10);
        step_req = 1'b0;
        chk("step_icnt", 32'(instr_count), 32'd101);
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        chk("step_hlt_T", 32'(T), 32'h00);
        chk("step_hlt_halted", 32'(halted), 32'd1);
        step_mode = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("step_resume_T", 32'(T), 32'h01);

        // Instance B: NUM_T = 5 walks T0..T4 and wraps
        b_reset = 1'b0;
        tick();
        chk("b_T0", 32'(b_T), 32'h01);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("b_walk_T", 32'(b_T), 32'(1 << i));
        end
        chk("b_ovf_before", 32'(b_ovf), 32'd0);
        tick();
        chk("b_wrap_T", 32'(b_T), 32'h01);
        chk("b_wrap_tcount", 32'(b_tcount), 32'd0);
        chk("b_wrap_ovf", 32'(b_ovf), 32'd1);
        chk("b_wrap_icnt", 32'(b_icnt), 32'd1);
        // Reset in the middle of a wait state
        tick();
        tick();
        b_wait = 1'b1;
        tick();
        chk("b_wait_T", 32'(b_T), 32'h04);
        b_reset = 1'b1;
        tick();
        chk("b_rst_T", 32'(b_T), 32'h00);
        chk("b_rst_icnt", 32'(b_icnt), 32'd0);
        chk("b_rst_ovf", 32'(b_ovf), 32'd0);
        chk("b_rst_tcount", 32'(b_tcount), 32'd0);
        b_reset = 1'b0;
        b_wait = 1'b0;
        tick();
        chk("b_restart_T", 32'(b_T), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_t_state_sequencer

// File: doc/t_state_sequencer.md
Name: t_state_sequencer

Overview:
Parametrised successor to the CPU's ad-hoc timing chain (3-bit counter, enable flop, T decoder, enable latch). It generates one-hot T-state strobes for the control unit. Beyond the current chain it adds a generic state count, memory wait-state stalls, single-step debug mode, halt/resume, wrap detection and an instruction-boundary counter. It sits between the control unit (which drives hlt/clr_timer combinationally from T and IR0) and the rest of the CPU.

Parameters:
T_WIDTH, 3, width of the internal T-state counter.
NUM_T, 8, number of T-states; 2 <= NUM_T <= 2**T_WIDTH.
ICNT_WIDTH, 16, width of the instruction-boundary counter.

Ports:
clk  input  1  system clock, all state updates on posedge.
reset  input  1  synchronous, active-high reset.
hlt  input  1  halt request from control unit.
clr_timer  input  1  end-of-instruction request; return to T0.
wait_req  input  1  memory/IO not ready; hold current T-state.
step_mode  input  1  1 = single-step debug mode.
step_req  input  1  single-cycle pulse permitting one advance in step mode.
run  input  1  resume pulse out of HALT.
T  output  NUM_T  one-hot T-state strobes (T[0] = fetch).
t_count  output  T_WIDTH  binary current T index.
halted  output  1  sequencer in HALT.
ovf_err  output  1  sticky: counter wrapped past NUM_T-1 without clr_timer.
instr_count  output  ICNT_WIDTH  number of completed instructions.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered or decoded from registers. Inputs are sampled at posedge and take effect in the next cycle.
- Reset (reset=1 at posedge): state=RUN, count=0, T=all zeros, halted=0, ovf_err=0, instr_count=0. A one-cycle internal "started" flag is cleared.
- First cycle after reset deassertion: T=one-hot T0. The counter does not advance on that first edge, so T0 lasts a full cycle.
- T = one-hot(count) in RUN (including step mode). T = 0 in HALT. t_count always equals count.
- States: RUN and HALT.
- RUN, per-cycle priority (highest first):
  1. hlt=1: next state HALT, count<=0. T reads zero from the next cycle. No instr_count increment.
  2. step_mode=1 and step_req=0: hold everything. clr_timer and wait_req are ignored until a step.
  3. wait_req=1: hold count. T stays asserted. clr_timer is deferred while wait_req is high.
  4. clr_timer=1: count<=0, instr_count+=1.
  5. Otherwise, if count==NUM_T-1: count<=0, ovf_err<=1, instr_count+=1. Else count<=count+1.
- HALT: halted=1, T=0, count=0. The state persists regardless of hlt, clr_timer, wait_req and step inputs.
  - run=1: next state RUN, T0 in the following cycle.
  - run and hlt in the same cycle while in HALT: run wins.
- Step mode: exactly one advance (or clear) per step_req pulse. A step_req held high for N cycles gives N advances. Toggling step_mode mid-instruction keeps the current count.
- instr_count wraps modulo 2**ICNT_WIDTH.
- ovf_err is cleared only by reset.
- Reset mid-instruction, mid-wait or in HALT: all state returns to reset values on that edge. There is no partial-state retention.

Decomposition:
- Shared defines header (cpu_defines): state encodings (ST_RUN, ST_HALT) and default NUM_T/T_WIDTH, so the control unit and CPU top agree.
- Sub-module: reuse the existing generic decoder (WIDTH=T_WIDTH, EN=run-and-started) for the count-to-T one-hot conversion. Outputs above NUM_T-1 are dropped.
- Everything else is inline.

Test Plan:
- Reset for 2 cycles, then release with NUM_T=8 and no inputs: T sequence is 0x01 for one cycle, then 0x02, 0x04 … 0x80, then 0x01. ovf_err rises on the wrap edge. instr_count becomes 1.
- clr_timer pulsed while T=0x02: next cycle T=0x01, instr_count+1, ovf_err stays 0. Repeat 100 times: instr_count=100.
- wait_req held 3 cycles at T=0x04 with clr_timer also high: T stays 0x04 for 4 cycles total, then T=0x01 on the cycle after wait_req drops.
- hlt at T=0x04: next cycle T=0x00 and halted=1, held for 20 cycles. Pulse run: halted=0, then T=0x01 the cycle after.
- step_mode=1 at T=0x02 with step_req pulsed every 5 cycles: T holds 0x02 for 5 cycles, then moves to 0x04. hlt in step mode without step_req halts immediately.
- NUM_T=5, T_WIDTH=3 instance: T cycles 0x01 through 0x10, then 0x01. Bits 7:5 are never present. Reset asserted mid-wait gives T=0x00 and instr_count=0.
